// File: rtl/ram_arbiter_mc_pkg.sv
// Shared definitions for the multi-channel RAM arbiter: FSM states, strobe polarity
// and default access hold times.
package ram_arbiter_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_ACT,
    ST_RD_ACT,
    ST_RECOVER
  } state_e;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam int unsigned DEF_WR_CYCLES = 6;
  localparam int unsigned DEF_RD_CYCLES = 6;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_mc_if.sv
// Request/response and RAM-side bus of ram_arbiter_mc; slave is the arbiter's view.
interface ram_arbiter_mc_if
  import ram_arbiter_mc_pkg::*;
#(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned NUM_RD = 4
);
  localparam int unsigned CH_W = idx_width(NUM_RD);

  logic                     wr_valid;
  logic                     wr_ready;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_new_file;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD-1:0]        rd_ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*ID_W-1:0]   rd_id;
  logic                     resp_valid;
  logic [DATA_W-1:0]        resp_data;
  logic [CH_W-1:0]          resp_ch;
  logic [ID_W-1:0]          resp_id;
  logic                     update;
  logic [ADDR_W-1:0]        start_addr;
  logic                     wr_wrapped;
  logic [ADDR_W-1:0]        ram_a;
  logic [DATA_W-1:0]        ram_dq_i;
  logic [DATA_W-1:0]        ram_dq_o;
  logic                     ram_cen;
  logic                     ram_oen;
  logic                     ram_wen;

  modport slave (
    input  wr_valid, wr_data, wr_new_file, rd_valid, rd_addr, rd_id, ram_dq_o,
    output wr_ready, rd_ready, resp_valid, resp_data, resp_ch, resp_id,
           update, start_addr, wr_wrapped, ram_a, ram_dq_i, ram_cen, ram_oen, ram_wen
  );

  modport master (
    output wr_valid, wr_data, wr_new_file, rd_valid, rd_addr, rd_id, ram_dq_o,
    input  wr_ready, rd_ready, resp_valid, resp_data, resp_ch, resp_id,
           update, start_addr, wr_wrapped, ram_a, ram_dq_i, ram_cen, ram_oen, ram_wen
  );

endinterface

// File: rtl/ram_arbiter_mc_rr_picker.sv
// Combinational round-robin picker: first request at or after ptr, cyclically.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IDX_W'((32'(ptr) + i) % N);
      if (!any && req[k]) begin
        gnt[k] = 1'b1;
        idx    = k;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter_mc.sv
// Serialises one write stream and NUM_RD read channels onto a single SRAM port.
// Optional write-starvation guard: define ARB_STARVE_GUARD_EN.
module ram_arbiter_mc
  import ram_arbiter_mc_pkg::*;
#(
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ID_W         = 4,
  parameter int unsigned NUM_RD       = 4,
  parameter int unsigned WR_CYCLES    = DEF_WR_CYCLES,
  parameter int unsigned RD_CYCLES    = DEF_RD_CYCLES,
  parameter int unsigned WR_ADDR_MAX  = 2**27 - 1,
  parameter int unsigned MAX_WR_BURST = 8
) (
  input logic             clk,
  input logic             reset_n,
  ram_arbiter_mc_if.slave bus
);

  localparam int unsigned CH_W    = idx_width(NUM_RD);
  localparam int unsigned MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int unsigned CNT_W   = idx_width(MAX_CYC);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              new_file_q, new_file_d;
  logic              wrapped_q, wrapped_d;
  logic              is_rd_q, is_rd_d;

  logic [NUM_RD-1:0] pick_gnt;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic              starve_block;
  logic              wr_ready;
  logic [NUM_RD-1:0] rd_ready;

  rr_picker #(
    .N    (NUM_RD),
    .IDX_W(CH_W)
  ) u_picker (
    .req(bus.rd_valid),
    .ptr(rr_ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned BURST_W = idx_width(MAX_WR_BURST + 1);
  logic [BURST_W-1:0] burst_q, burst_d;

  // Once the limit is hit the write is masked, so the count never exceeds it.
  assign starve_block = (burst_q == BURST_W'(MAX_WR_BURST)) && (|bus.rd_valid);

  always_comb begin
    burst_d = burst_q;
    if (rd_ready != '0)                    burst_d = '0;
    else if (wr_ready && |bus.rd_valid)    burst_d = burst_q + 1'b1;
    else if (!(|bus.rd_valid))             burst_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) burst_q <= '0;
    else          burst_q <= burst_d;
  end
`else
  assign starve_block = (MAX_WR_BURST == 0) && 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    addr_d       = addr_q;
    start_addr_d = start_addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    id_d         = id_q;
    ch_d         = ch_q;
    rr_ptr_d     = rr_ptr_q;
    new_file_d   = new_file_q;
    wrapped_d    = wrapped_q;
    is_rd_d      = is_rd_q;
    wr_ready       = 1'b0;
    rd_ready       = '0;
    bus.resp_valid = 1'b0;
    bus.update     = 1'b0;
    bus.ram_a      = '0;
    bus.ram_dq_i   = '0;
    bus.ram_cen    = STROBE_OFF;
    bus.ram_oen    = STROBE_OFF;
    bus.ram_wen    = STROBE_OFF;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.wr_valid && !starve_block) begin
          wr_ready   = 1'b1;
          wdata_d    = bus.wr_data;
          new_file_d = bus.wr_new_file;
          is_rd_d    = 1'b0;
          if (bus.wr_new_file) start_addr_d = wr_ptr_q;
          state_d    = ST_WR_ACT;
        end else if (pick_any) begin
          rd_ready = pick_gnt;
          addr_d   = bus.rd_addr[pick_idx*ADDR_W +: ADDR_W];
          id_d     = bus.rd_id[pick_idx*ID_W +: ID_W];
          ch_d     = pick_idx;
          rr_ptr_d = (32'(pick_idx) == NUM_RD - 1) ? '0 : pick_idx + 1'b1;
          is_rd_d  = 1'b1;
          state_d  = ST_RD_ACT;
        end
      end
      ST_WR_ACT: begin
        bus.ram_a    = wr_ptr_q;
        bus.ram_dq_i = wdata_q;
        bus.ram_cen  = STROBE_ON;
        bus.ram_wen  = STROBE_ON;
        bus.update   = new_file_q && (cnt_q == '0);
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          if (wr_ptr_q == ADDR_W'(WR_ADDR_MAX)) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          state_d = ST_RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RD_ACT: begin
        bus.ram_a   = addr_q;
        bus.ram_cen = STROBE_ON;
        bus.ram_oen = STROBE_ON;
        if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
          rdata_d = bus.ram_dq_o;
          state_d = ST_RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        bus.resp_valid = is_rd_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.rd_ready   = rd_ready;
  assign bus.resp_data  = rdata_q;
  assign bus.resp_ch    = ch_q;
  assign bus.resp_id    = id_q;
  assign bus.start_addr = start_addr_q;
  assign bus.wr_wrapped = wrapped_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      addr_q       <= '0;
      start_addr_q <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      id_q         <= '0;
      ch_q         <= '0;
      rr_ptr_q     <= '0;
      new_file_q   <= 1'b0;
      wrapped_q    <= 1'b0;
      is_rd_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      addr_q       <= addr_d;
      start_addr_q <= start_addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      id_q         <= id_d;
      ch_q         <= ch_d;
      rr_ptr_q     <= rr_ptr_d;
      new_file_q   <= new_file_d;
      wrapped_q    <= wrapped_d;
      is_rd_q      <= is_rd_d;
    end
  end

endmodule

// File: doc/ram_arbiter_mc.md
Name: ram_arbiter_mc

Overview:
- Parametrised successor to the single-stream SD/playback RAM arbiter.
- Serialises one write stream (SD loader) and NUM_RD independent read channels (playback voices) onto one SRAM-style RAM port.
- Replaces the request-FIFO IP with per-source valid/ready handshakes: write priority, round-robin among reads, programmable strobe hold times, wrapping write pointer.
- Sits between the SD controller / playback voices and the RAM interface; also feeds samplectl with file start addresses.

Parameters:
- ADDR_W, 27, RAM address width
- DATA_W, 16, sample width
- ID_W, 4, read request tag width
- NUM_RD, 4, number of read channels (1..8)
- WR_CYCLES, 6, cycles the write strobes are held (>=1)
- RD_CYCLES, 6, cycles the read strobes are held; data sampled in the last one (>=1)
- WR_ADDR_MAX, 2**27-1, last writable address; the write pointer wraps after it
- MAX_WR_BURST, 8, write-starvation limit (optional feature only)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request present
- wr_ready  out  1  write accepted this cycle when wr_valid is also high
- wr_data  in  DATA_W  sample to store
- wr_new_file  in  1  sample is the first of a new file
- rd_valid  in  NUM_RD  per-channel read request
- rd_ready  out  NUM_RD  per-channel accept, one-hot or zero
- rd_addr  in  NUM_RD*ADDR_W  flattened; channel k at [k*ADDR_W +: ADDR_W]
- rd_id  in  NUM_RD*ID_W  flattened request tags
- resp_valid  out  1  one-cycle read-data pulse
- resp_data  out  DATA_W  read data
- resp_ch  out  $clog2(NUM_RD) (min 1)  channel index of the response
- resp_id  out  ID_W  tag of the response
- update  out  1  one-cycle pulse: new file start address is valid
- start_addr  out  ADDR_W  RAM address of the first sample of the new file
- wr_wrapped  out  1  sticky; set on the first write-pointer wrap
- ram_a  out  ADDR_W  RAM address
- ram_dq_i  out  DATA_W  RAM write data
- ram_dq_o  in  DATA_W  RAM read data
- ram_cen, ram_oen, ram_wen  out  1  active-low RAM strobes

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access): strobes=1; all other outputs 0; wr_ptr=0; round-robin pointer=0; state=IDLE. No partial response is emitted after reset.
- States: IDLE, WR_ACT, RD_ACT, RECOVER.
- IDLE, per cycle:
  - If wr_valid: wr_ready=1 -> WR_ACT.
  - Else if any rd_valid: grant the first requesting channel at or after rr_ptr (cyclic); rd_ready[g]=1; latch addr and id; rr_ptr<=g+1 mod NUM_RD -> RD_ACT.
  - Ready signals are combinational from state and valids; accept means valid&&ready in the same cycle.
- WR_ACT, D=WR_CYCLES cycles:
  - ram_a=wr_ptr, ram_dq_i=latched data, cen=0, wen=0, oen=1.
  - On exit: wr_ptr <= (wr_ptr==WR_ADDR_MAX) ? 0 : wr_ptr+1; the wrap sets wr_wrapped.
- New file: if wr_new_file was latched, update=1 for exactly one cycle (the first WR_ACT cycle) with start_addr=wr_ptr. start_addr holds until the next update.
- RD_ACT, D=RD_CYCLES cycles: ram_a=latched addr, cen=0, oen=0, wen=1. ram_dq_o is sampled on the last cycle.
- RECOVER, 1 cycle:
  - All strobes=1.
  - After a read: resp_valid=1 with resp_data, resp_ch, resp_id.
  - -> IDLE.
- Timing: accept at cycle t -> strobes active t+1..t+D -> resp_valid at t+D+1 -> next accept possible at t+D+2.
- Simultaneous write and reads: write wins; reads wait and rr_ptr is unchanged.
- Back-to-back writes on a wr_valid held high never skip or repeat an address.
- A read requester may drop rd_valid before acceptance without side effects.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive writes granted while any rd_valid was high.
  - When the count reaches MAX_WR_BURST, the next IDLE grant goes to a read (round-robin) even if wr_valid is high.
  - The counter clears on any read grant or when no read is pending.
- Undefined: strict write priority; the counter logic is absent.

Decomposition:
- Shared package (globalparams extension): state encodings; strobe-polarity constants; default WR_CYCLES/RD_CYCLES replacing RAM_WRITE_DELAY/RAM_READ_DELAY.
- Sub-module rr_picker: NUM_RD-wide request vector plus pointer in -> one-hot grant and index out. Purely combinational; reused by future mixers.

Test Plan:
- Single write: wr_data=16'h1234, new_file=1, wr_ptr=0 -> wen=cen=0 for 6 cycles at ram_a=0; update pulse with start_addr=0; next write lands at address 1.
- Read: channel 2, rd_addr=0x40, id=5, RAM model returns 0xBEEF -> resp_valid exactly 7 cycles after accept; resp_ch=2, resp_id=5, resp_data=0xBEEF.
- All 4 channels valid continuously -> grant order 0,1,2,3,0; exactly one rd_ready per accept.
- wr_valid and rd_valid[1] both high -> write served first, then the read; without ARB_STARVE_GUARD_EN, wr_valid held high for 20 writes starves the read; with the macro, the read is granted after 8 writes.
- WR_ADDR_MAX=3, 5 writes -> addresses 0,1,2,3,0; wr_wrapped rises on the 4th write's exit.
- reset_n low during RD_ACT cycle 3 -> strobes high immediately, no resp_valid; after release the first accept proceeds normally.
